// File: rtl/alarm_event_logger_pkg.sv
// Shared state encodings and default widths for the alarm episode logger.
package alarm_event_logger_pkg;

  typedef enum logic [1:0] {
    LOG_IDLE   = 2'd0,
    LOG_ACTIVE = 2'd1,
    LOG_COMMIT = 2'd2
  } log_state_e;

  localparam int LOG_IDX_W   = 3;
  localparam int LOG_DUR_W   = 8;
  localparam int LOG_CNT_W   = 8;
  localparam int LOG_STAMP_W = 16;

endpackage

// File: rtl/alarm_event_logger_ram.sv
// Episode storage: register array, one synchronous write port, one registered read port.
module alarm_log_ram #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3,
  parameter int W     = 8
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [W-1:0]     rdata
);

  logic [W-1:0] mem [DEPTH];

  // Storage is not reset; the logger masks stale slots with its fill count.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/alarm_event_logger.sv
// Measures siren episodes in seconds and logs the last DEPTH durations (index 0 = newest).
// Optional LOG_TIMESTAMP_EN adds a seconds-since-reset start stamp per entry.
module alarm_event_logger
  import alarm_event_logger_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = LOG_IDX_W,
  parameter int DUR_W = LOG_DUR_W,
  parameter int CNT_W = LOG_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             one_hz_enable,
  input  logic             siren_on,
  input  logic             status,
  input  logic             clear,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [DUR_W-1:0] rd_data,
  output logic             rd_valid,
  output logic [15:0]      rd_stamp,
  output logic [CNT_W-1:0] event_count,
  output logic             logging
);

  localparam logic [DUR_W-1:0] DUR_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W:0]   FILL_MAX = (IDX_W+1)'(DEPTH);

  log_state_e       state, state_n;
  logic [DUR_W-1:0] dur;
  logic [IDX_W-1:0] wr_ptr, rd_slot;
  logic [IDX_W:0]   fill;
  logic             commit, start;

  assign commit  = (state == LOG_COMMIT) && !clear;
  assign start   = (state == LOG_IDLE) && siren_on && !clear;
  assign logging = (state == LOG_ACTIVE);
  assign rd_slot = wr_ptr - IDX_W'(1) - rd_idx;

  always_comb begin
    state_n = state;
    case (state)
      LOG_IDLE:   if (siren_on) state_n = LOG_ACTIVE;
      LOG_ACTIVE: if (!siren_on) state_n = LOG_COMMIT;
      LOG_COMMIT: state_n = LOG_IDLE;
      default:    state_n = LOG_IDLE;
    endcase
    if (clear) state_n = LOG_IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= LOG_IDLE;
      dur         <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      event_count <= '0;
    end else begin
      state <= state_n;
      if (clear) begin
        dur         <= '0;
        wr_ptr      <= '0;
        fill        <= '0;
        event_count <= '0;
      end else begin
        if (start) dur <= '0;
        else if (logging && siren_on && one_hz_enable && dur != DUR_MAX) dur <= dur + 1'b1;
        if (commit) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (fill != FILL_MAX) fill <= fill + 1'b1;
          if (event_count != CNT_MAX) event_count <= event_count + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) rd_valid <= 1'b0;
    else       rd_valid <= ({1'b0, rd_idx} < fill);
  end

`ifdef LOG_TIMESTAMP_EN
  localparam int W = DUR_W + LOG_STAMP_W;
  logic [15:0] secs, stamp;
  logic [W-1:0] wdata, rdata;

  // Free-running seconds counter; survives clear so stamps stay comparable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      secs  <= '0;
      stamp <= '0;
    end else begin
      if (one_hz_enable) secs <= secs + 1'b1;
      if (start) stamp <= secs;
    end
  end

  assign wdata    = {stamp, dur};
  assign rd_data  = rd_valid ? rdata[DUR_W-1:0] : '0;
  assign rd_stamp = rd_valid ? rdata[DUR_W +: 16] : '0;
`else
  localparam int W = DUR_W;
  logic [W-1:0] wdata, rdata;

  assign wdata    = dur;
  assign rd_data  = rd_valid ? rdata : '0;
  assign rd_stamp = 16'd0;
`endif

  alarm_log_ram #(.DEPTH(DEPTH), .IDX_W(IDX_W), .W(W)) u_ram (
    .clock (clock),
    .we    (commit),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_slot),
    .rdata (rdata)
  );

  logic unused;
  assign unused = status;

endmodule

// File: tb/tb_alarm_event_logger.sv
// Directed scoreboard bench for alarm_event_logger (DEPTH=8, DUR_W=8, CNT_W=8).
module tb_alarm_event_logger;

  logic        clock = 0, reset = 1, one_hz_enable = 0, siren_on = 0, status = 0, clear = 0;
  logic [2:0]  rd_idx = 0;
  logic [7:0]  rd_data, event_count;
  logic        rd_valid, logging;
  logic [15:0] rd_stamp;

  alarm_event_logger dut (
    .clock(clock), .reset(reset), .one_hz_enable(one_hz_enable), .siren_on(siren_on),
    .status(status), .clear(clear), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_stamp(rd_stamp), .event_count(event_count), .logging(logging)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [7:0]  data;
    logic        valid;
    logic [7:0]  cnt;
    logic        logg;
    logic [15:0] stamp;
    bit          scare;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;

  // Monitor: one expectation consumed per falling edge once pushed.
  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_tests++;
      if (rd_data !== e.data || rd_valid !== e.valid || event_count !== e.cnt ||
          logging !== e.logg || (e.scare && rd_stamp !== e.stamp)) begin
        n_fail++;
        $display("FAIL %s: got data=%0d valid=%0b cnt=%0d logging=%0b stamp=%0d, want data=%0d valid=%0b cnt=%0d logging=%0b stamp=%0d",
                 e.name, rd_data, rd_valid, event_count, logging, rd_stamp,
                 e.data, e.valid, e.cnt, e.logg, e.stamp);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tick();
    one_hz_enable = 1; cyc(1); one_hz_enable = 0;
  endtask

  task automatic episode(input int d);
    siren_on = 1; cyc(1);
    repeat (d) tick();
    siren_on = 0; cyc(2);
  endtask

  task automatic do_clear();
    clear = 1; cyc(1); clear = 0; cyc(1);
  endtask

  task automatic chk(input string name, input int idx, input int data, input bit valid,
                     input int cnt, input bit logg, input int stamp, input bit stamp_care);
    exp_t e;
    rd_idx = 3'(idx);
    cyc(1);
    e.name = name; e.data = 8'(data); e.valid = valid; e.cnt = 8'(cnt); e.logg = logg;
`ifdef LOG_TIMESTAMP_EN
    e.stamp = 16'(stamp); e.scare = stamp_care;
`else
    e.stamp = 16'd0; e.scare = 1'b1;
`endif
    q.push_back(e);
    cyc(1);
  endtask

  initial begin
    cyc(2);
    reset = 0; cyc(1);
    chk("reset", 0, 0, 0, 0, 0, 0, 0);

    // 1: single 3-second episode
    episode(3);
    chk("t1_idx0", 0, 3, 1, 1, 0, 0, 0);
    chk("t1_idx1", 1, 0, 0, 1, 0, 0, 0);

    // 2: ten episodes overflow the 8-deep log
    do_clear();
    chk("t2_cleared", 0, 0, 0, 0, 0, 0, 0);
    for (int d = 1; d <= 10; d++) episode(d);
    for (int i = 0; i < 8; i++) chk($sformatf("t2_idx%0d", i), i, 10 - i, 1, 10, 0, 0, 0);

    // 3: duration saturates
    do_clear();
    episode(300);
    chk("t3_sat", 0, 255, 1, 1, 0, 0, 0);

    // 4: clear mid-episode drops it
    do_clear();
    siren_on = 1; cyc(1);
    tick(); tick();
    clear = 1; cyc(1);
    chk("t4_clear_hold", 0, 0, 0, 0, 0, 0, 0);
    siren_on = 0; clear = 0; cyc(3);
    chk("t4_no_entry", 0, 0, 0, 0, 0, 0, 0);

    // 5: 1-cycle drop between episodes, tick on rise ignored
    siren_on = 1; cyc(1);
    tick(); tick();
    siren_on = 0; cyc(1);
    siren_on = 1; cyc(1);
    one_hz_enable = 1; cyc(1); one_hz_enable = 0;
    tick();
    siren_on = 0; cyc(2);
    chk("t5_second", 0, 1, 1, 2, 0, 0, 0);
    chk("t5_first", 1, 2, 1, 2, 0, 0, 0);
    episode(0);
    chk("t5_pulse", 0, 0, 1, 3, 0, 0, 0);
    chk("t5_logging", 0, 0, 1, 3, 0, 0, 0);

    // event counter saturation
    do_clear();
    for (int i = 0; i < 256; i++) episode(0);
    chk("cnt_sat", 0, 0, 1, 255, 0, 0, 0);

    // reset mid-episode
    siren_on = 1; cyc(1);
    tick();
    chk("active_logging", 7, 0, 1, 255, 1, 0, 0);
    reset = 1; cyc(1); reset = 0; siren_on = 0; cyc(1);
    chk("reset_mid", 0, 0, 0, 0, 0, 0, 0);

    // 6: timestamp after 5 idle seconds
    repeat (5) begin tick(); cyc(1); end
    episode(2);
    chk("t6_stamp", 0, 2, 1, 1, 0, 5, 1);

    repeat (3) @(negedge clock);
    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
